lcd_split_driver: RTL

- Parametrised RGB LCD timing generator with a built-in two-channel compositor, replacing fixed per-panel timing tables.
- Generates HS/VS/DE and pixel coordinates for any panel geometry.
- Issues per-channel pixel read requests to two frame-buffer readers (dual camera), compensating for their read latency.
- Drives RGB data directly in one of four modes: ch0 full screen, ch1 full screen, side-by-side split, colour-bar test.

---
 rtl/lcd_split_driver.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_split_driver.sv
// Parametrised RGB LCD timing generator with a built-in two-channel compositor.
// Pixel requests go out combinationally; hs/vs/de/rgb reach the pins RD_LAT+1 clocks later.
`timescale 1ns/1ps
module lcd_split_driver #(
    parameter int                H_SYNC   = 1,
    parameter int                H_BACK   = 46,
    parameter int                H_DISP   = 800,
    parameter int                H_FRONT  = 210,
    parameter int                V_SYNC   = 1,
    parameter int                V_BACK   = 23,
    parameter int                V_DISP   = 480,
    parameter int                V_FRONT  = 22,
    parameter int                DATA_W   = 16,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] BG_COLOR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [12:0]       ch_h_pixel,
    output logic              rd0_en,
    input  logic [DATA_W-1:0] rd0_data,
    output logic              rd1_en,
    input  logic [DATA_W-1:0] rd1_data,
    output logic [10:0]       pixel_xpos,
    output logic [10:0]       pixel_ypos,
    output logic              frame_start,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb
);

    localparam int CW      = 12;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT_S = H_SYNC + H_BACK;
    localparam int H_ACT_E = H_ACT_S + H_DISP;
    localparam int V_ACT_S = V_SYNC + V_BACK;
    localparam int V_ACT_E = V_ACT_S + V_DISP;
    localparam int HALF    = H_DISP / 2;

    typedef enum logic [1:0] {
        SEL_BG  = 2'd0,
        SEL_CH0 = 2'd1,
        SEL_CH1 = 2'd2,
        SEL_BAR = 2'd3
    } sel_e;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        sel_e       sel;
        logic [2:0] bar;
    } tap_t;

    localparam tap_t TAP_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, sel: SEL_BG, bar: 3'd0};

    // RGB565 colour-bar palette, left to right
    function automatic logic [DATA_W-1:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return DATA_W'(c);
    endfunction

    logic [CW-1:0]     h_cnt_q, h_cnt_d;
    logic [CW-1:0]     v_cnt_q, v_cnt_d;
    logic [1:0]        mode_q;
    logic              h_act_s, v_act_s, act_s;
    logic              frame_start_s;
    logic [10:0]       x_s, y_s, x_right_s;
    logic              rd0_s, rd1_s;
    sel_e              sel_s;
    logic [2:0]        bar_s;
    tap_t              tap_s;
    tap_t              dly_q [RD_LAT];
    tap_t              tail_s;
    logic              hs_q, vs_q, de_q;
    logic [DATA_W-1:0] rgb_q, rgb_d;

    // Raster counter next state: h wraps every line, v advances on each h wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == CW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 12'd1;
        end else begin
            h_cnt_d = h_cnt_q + 12'd1;
        end
    end

    // Raster counters and per-frame mode latch
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= 2'b00;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            mode_q  <= frame_start_s ? mode : mode_q;
        end
    end

    // Active-area decode and coordinates; reset forces everything idle
    always_comb begin
        h_act_s       = (h_cnt_q >= CW'(H_ACT_S)) && (h_cnt_q < CW'(H_ACT_E));
        v_act_s       = (v_cnt_q >= CW'(V_ACT_S)) && (v_cnt_q < CW'(V_ACT_E));
        act_s         = h_act_s && v_act_s && !rst;
        x_s           = act_s ? 11'(h_cnt_q - CW'(H_ACT_S)) : 11'd0;
        y_s           = act_s ? 11'(v_cnt_q - CW'(V_ACT_S)) : 11'd0;
        x_right_s     = x_s - 11'(HALF);
        frame_start_s = !rst && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Per-channel read requests; at most one channel owns any pixel
    always_comb begin
        rd0_s = 1'b0;
        rd1_s = 1'b0;
        case (mode_q)
            2'b00: rd0_s = act_s && ({2'b00, x_s} < ch_h_pixel);
            2'b01: rd1_s = act_s && ({2'b00, x_s} < ch_h_pixel);
            2'b10: begin
                if (x_s < 11'(HALF)) begin
                    rd0_s = act_s && ({2'b00, x_s} < ch_h_pixel);
                end else begin
                    rd1_s = act_s && ({2'b00, x_right_s} < ch_h_pixel);
                end
            end
            default: begin
                rd0_s = 1'b0;
                rd1_s = 1'b0;
            end
        endcase
    end

    // Source select; a pixel without a request falls back to the background
    always_comb begin
        sel_s = SEL_BG;
        if (mode_q == 2'b11) begin
            sel_s = SEL_BAR;
        end else if (rd0_s) begin
            sel_s = SEL_CH0;
        end else if (rd1_s) begin
            sel_s = SEL_CH1;
        end else begin
            sel_s = SEL_BG;
        end
    end

    // Bar index = floor(x*8/H_DISP), found by comparing x*8 against each k*H_DISP
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_s = ({2'b00, x_s, 3'b000} >= 16'(k * H_DISP)) ? 3'(k) : bar_s;
        end
    end

    // Everything the output stage needs about this raster position
    always_comb begin
        tap_s     = TAP_IDLE;
        tap_s.hs  = (h_cnt_q >= CW'(H_SYNC));
        tap_s.vs  = (v_cnt_q >= CW'(V_SYNC));
        tap_s.act = act_s;
        tap_s.sel = sel_s;
        tap_s.bar = bar_s;
    end

    // Delay line matching the frame-buffer read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= TAP_IDLE;
            end
        end else begin
            dly_q[0] <= tap_s;
            for (int i = 1; i < RD_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign tail_s = dly_q[RD_LAT-1];

    // Pixel mux at the tail, where requested read data is now valid
    always_comb begin
        rgb_d = '0;
        if (tail_s.act) begin
            case (tail_s.sel)
                SEL_CH0: rgb_d = rd0_data;
                SEL_CH1: rgb_d = rd1_data;
                SEL_BAR: rgb_d = bar_color(tail_s.bar);
                default: rgb_d = BG_COLOR;
            endcase
        end else begin
            rgb_d = '0;
        end
    end

    // Output register; hs, vs, de and rgb share one pipeline so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= tail_s.hs;
            vs_q  <= tail_s.vs;
            de_q  <= tail_s.act;
            rgb_q <= rgb_d;
        end
    end

    assign rd0_en      = rd0_s;
    assign rd1_en      = rd1_s;
    assign pixel_xpos  = x_s;
    assign pixel_ypos  = y_s;
    assign frame_start = frame_start_s;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign lcd_rgb     = rgb_q;

endmodule
